// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared opcode constants and sequencer FSM state encoding for the
//            8-bit ALU and its command front-end.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU select codes, driven on alu_sel
  localparam logic [2:0] ALU_ADD = 3'b000;  // A + B, wraps modulo 256
  localparam logic [2:0] ALU_SHL = 3'b001;  // A << 1, logical
  localparam logic [2:0] ALU_SHR = 3'b010;  // A >> 1, logical
  localparam logic [2:0] ALU_CNT = 3'b011;  // ALU free-running counter
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_NOP = 3'b111;  // result is 0

  // Data width of the ALU datapath
  localparam int DATA_W = 8;

  // Sequencer states: accept, hold operands for the ALU, write back
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  // Operand B selection: immediate or register read
  function automatic logic [DATA_W-1:0] sel_operand_b(
    input logic              use_imm,
    input logic [DATA_W-1:0] imm,
    input logic [DATA_W-1:0] reg_val
  );
    return use_imm ? imm : reg_val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : alu_regfile
// Brief    : NREG x 8-bit register file with asynchronous reset, one
//            synchronous write port and three combinational read ports
//            (operand A, operand B, debug).
// Revision : 1.0 - initial release
// ============================================================================
module alu_regfile
  import alu_pkg::*;
#(
  parameter  int NREG = 4,
  localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr_a,
  input  logic [AW-1:0]     i_raddr_b,
  input  logic [AW-1:0]     i_raddr_d,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic [DATA_W-1:0] o_rdata_d
);

  logic [DATA_W-1:0] r_mem [NREG];

  // Storage: cleared on reset, single write per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Reads are unregistered, so a write becomes visible only after its edge
  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];
  assign o_rdata_d = r_mem[i_raddr_d];

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Brief    : Command front-end for the 8-bit ALU. Accepts one command at a
//            time, reads operands from an internal register file, drives the
//            ALU, captures its result and writes it back. Three cycles per
//            command: IDLE (accept) -> ISSUE (ALU evaluates) -> WB (write).
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter  int NREG = 4,
  localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              reset,
  // command handshake
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [AW-1:0]     cmd_dst,
  input  logic [AW-1:0]     cmd_srca,
  input  logic [AW-1:0]     cmd_srcb,
  input  logic              cmd_use_imm,
  input  logic [DATA_W-1:0] cmd_imm,
  // ALU side
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  // completion
  output logic              done,
  output logic [AW-1:0]     done_dst,
  output logic [DATA_W-1:0] done_data,
  // debug read
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_accept;
  logic              w_capture;
  logic              w_wb;
  logic              w_ready;

  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [2:0]        r_alu_sel;
  logic [AW-1:0]     r_dst;
  logic [DATA_W-1:0] r_result;

  logic [DATA_W-1:0] w_rdata_a;
  logic [DATA_W-1:0] w_rdata_b;
  logic [DATA_W-1:0] w_opb;

  // Operand storage; write-back happens only in the WB state
  alu_regfile #(
    .NREG (NREG)
  ) u_regfile (
    .clk       (clk),
    .rst       (reset),
    .i_we      (w_wb),
    .i_waddr   (r_dst),
    .i_wdata   (r_result),
    .i_raddr_a (cmd_srca),
    .i_raddr_b (cmd_srcb),
    .i_raddr_d (rd_addr),
    .o_rdata_a (w_rdata_a),
    .o_rdata_b (w_rdata_b),
    .o_rdata_d (rd_data)
  );

  assign w_opb = sel_operand_b(cmd_use_imm, cmd_imm, w_rdata_b);

  // FSM state register; reset abandons any command in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-state strobes; commands outside IDLE are ignored
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_wb         = 1'b0;
    w_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (cmd_valid) begin
          w_accept     = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        w_capture    = 1'b1;
        w_state_next = WB;
      end
      WB: begin
        w_wb         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath: operands sampled at accept (so dst==src sees the old value),
  // result captured at the end of ISSUE, select parked on NOP after WB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= ALU_NOP;
      r_dst     <= '0;
      r_result  <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a   <= w_rdata_a;
        r_alu_b   <= w_opb;
        r_alu_sel <= cmd_op;
        r_dst     <= cmd_dst;
      end
      if (w_capture) begin
        r_result <= alu_result;
      end
      if (w_wb) begin
        r_alu_sel <= ALU_NOP;
      end
    end
  end

  assign cmd_ready = w_ready;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign done      = w_wb;
  assign done_dst  = r_dst;
  assign done_data = r_result;

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front-end for the 8-bit `ALU` block. Accepts one operation command at a time over a valid/ready handshake and reads operands from a small internal register file. It drives `A`/`B`/`sel` into the ALU, captures the ALU `Result` one cycle later and writes it back to a destination register. It sits directly upstream of the ALU and also consumes its output, so the pair forms a minimal register-to-register datapath.

## Interface
- `NREG`, 4: number of 8-bit registers; power of two; address width `AW = $clog2(NREG)`.
- `clk`  in  1: single clock, rising edge; the ALU shares the same `clk`.
- `reset`  in  1: asynchronous, active-high; the ALU shares the same `reset`.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: sequencer can accept a command.
- `cmd_op`  in  3: ALU select code, passed through to `alu_sel`.
- `cmd_dst`  in  AW: destination register.
- `cmd_srca`  in  AW: source register for operand A.
- `cmd_srcb`  in  AW: source register for operand B.
- `cmd_use_imm`  in  1: when 1, operand B = `cmd_imm` instead of `reg[cmd_srcb]`.
- `cmd_imm`  in  8: immediate operand.
- `alu_a`  out  8: drives ALU `A`.
- `alu_b`  out  8: drives ALU `B`.
- `alu_sel`  out  3: drives ALU `sel`.
- `alu_result`  in  8: from ALU `Result` (combinational in the ALU).
- `done`  out  1: one-cycle pulse when a result is written back.
- `done_dst`  out  AW: register written; valid with `done`.
- `done_data`  out  8: value written; valid with `done`.
- `rd_addr`  in  AW: debug read address.
- `rd_data`  out  8: combinational read of `reg[rd_addr]`.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1. On `cmd_valid & cmd_ready`, latch `op`/`dst`, load `alu_a`=reg[srca], `alu_b`=imm or reg[srcb], `alu_sel`=op; go to ISSUE.
  - ISSUE: hold `alu_*` stable; capture `alu_result` into the internal result register at the end of the cycle; go to WB.
  - WB: write reg[dst] = captured result; assert `done`, `done_dst`, `done_data`; restore `alu_sel`=3'b111 (no-op); go to IDLE.
- Operands are sampled at accept, so `dst == srca/srcb` uses the old value.
- Commands are serial, so no data hazard exists.
- Arithmetic width is set by the ALU: add wraps modulo 256, shifts are logical 1-bit.
- `sel`=011 returns the ALU's free-running counter value as seen during ISSUE.
- `sel`=111 writes 0 to `dst`.
- `cmd_ready` is low in ISSUE and WB. `cmd_valid` during those states is ignored, not queued.
- Reset values: state IDLE, `cmd_ready`=1, `alu_a`=0, `alu_b`=0, `alu_sel`=3'b111, `done`=0, `done_dst`=0, `done_data`=0, all registers 0.
- Reset asserted mid-command abandons it: no write, no `done`.

## Timing
- Accept at edge N.
- `alu_*` valid from N to N+1; result captured at edge N+1.
- `done` high from N+1 to N+2; the register write lands at edge N+2.
- `rd_data` shows the new value after edge N+2.
- `cmd_ready` is high again after edge N+2, so the next accept is at the earliest at edge N+3.
- Throughput: one command per 3 cycles.
- `rd_data` has zero latency (combinational). When `rd_addr` matches the register being written, it shows the old value during the WB cycle.
- `done` is never asserted for more than one consecutive cycle.

## Structure
- Shared package `alu_pkg`:
  - opcode constants `ALU_ADD`=000, `ALU_SHL`=001, `ALU_SHR`=010, `ALU_CNT`=011, `ALU_AND`=100, `ALU_OR`=101, `ALU_XOR`=110, `ALU_NOP`=111;
  - FSM state enum {IDLE, ISSUE, WB}.
- Sub-module `alu_regfile`: NREG×8 flops with async reset.
  - Two combinational read ports for operands, one for debug.
  - One synchronous write port.
- Top level holds the FSM, the latched command fields and the result capture register. The ALU is instantiated alongside at integration, not inside.

## Test plan
- **Reset and post-reset state:** check all listed reset values, then set `rd_addr`=0..3.
  - Required: `rd_data`=0 for every address.
- **Immediate load:** `ALU_ADD` with srca=r0, imm=8'h5A, `use_imm`=1, dst=r1.
  - Required: `done` 2 cycles after accept, `done_data`=8'h5A, `done_dst`=1, then r1=8'h5A.
- **Wrap-around:** r1=8'hF0, r2=8'h20 (both loaded via immediates), `ALU_ADD` r1+r2 into r3.
  - Required: r3=8'h10.
- **Shifts:** r1=8'h81.
  - `ALU_SHL` → 8'h02.
  - `ALU_SHR` → 8'h40.
- **Handshake:** hold `cmd_valid` high continuously with commands A, B.
  - Required: accepts exactly 3 cycles apart, `cmd_ready` low in ISSUE and WB, B reads A's written result.
  - Also: `dst==srca` uses the old value.
- **Reset mid-command:** assert `reset` during ISSUE.
  - Required: no `done`, destination register stays 0, `cmd_ready`=1 after release.
  - Required: `ALU_NOP` writes 0.
